// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the debug unit: command bytes,
// dump frame geometry and the controller state type.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int WORD_BYTES  = 4;
  localparam int FRAME_WORDS = 34;   // PC + 32 registers + cycle counter
  localparam int FRAME_BYTES = 136;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CNT,
    S_LOAD_DATA,
    S_RUN,
    S_STEP,
    S_DUMP_FETCH,
    S_DUMP_SEND,
    S_DUMP_WAIT
  } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Splits a latched word into bytes (MSB first) and runs the tx handshake:
// one start strobe per byte, then a one-cycle hold-off before the next byte.
module debug_tx_serializer
  import debug_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [NB_DATA-1:0] word,
  input  logic               send,
  input  logic               waiting,
  input  logic               tx_ready,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               word_done,
  output logic               frame_done
);

  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int NB_WC = $clog2(BPW + 1);
  localparam int NB_FC = $clog2(FRAME_BYTES + 1);

  logic [NB_DATA-1:0] shreg;
  logic [NB_WC-1:0]   word_cnt;
  logic [NB_FC-1:0]   frame_cnt;

  assign tx_start   = send && tx_ready;
  assign tx_data    = shreg[NB_DATA-1 -: NB_BYTE];
  // Both flags are only meaningful in the hold-off cycle after a byte went out.
  assign word_done  = waiting && (word_cnt == NB_WC'(BPW));
  assign frame_done = waiting && (frame_cnt == NB_FC'(FRAME_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      word_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (load) begin
        shreg    <= word;
        word_cnt <= '0;
      end else if (tx_start) begin
        shreg     <= shreg << NB_BYTE;
        word_cnt  <= word_cnt + 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (frame_done) frame_cnt <= '0;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Serial debug controller: loads instruction memory, runs or single-steps the
// processor, then streams a 136-byte state dump (PC, registers, cycle count).
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_BYTE      = 8,
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_valid,
  output logic [NB_BYTE-1:0]      o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_ready,
  output logic                    o_imem_wr_enb,
  output logic [NB_IMEM_ADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0]      o_imem_wr_data,
  output logic                    o_mips_enable,
  input  logic                    i_halt,
  input  logic [NB_DATA-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0]  o_dump_addr,
  input  logic [NB_DATA-1:0]      i_dump_data
);

  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int ASM_W = NB_DATA - NB_BYTE;

  state_t                  state, state_nxt;
  logic [31:0]             cycle_cnt;
  logic [ASM_W-1:0]        asm_word;
  logic [3:0]              byte_idx;
  logic [NB_BYTE-1:0]      words_left;
  logic [NB_IMEM_ADDR-1:0] word_addr;
  logic [5:0]              word_idx;
  logic [NB_DATA-1:0]      fetch_word;
  logic                    word_done, frame_done;
  logic                    load_empty, load_last, byte_last;

  assign byte_last  = (byte_idx == 4'(BPW - 1));
  assign load_empty = (state == S_LOAD_CNT) && i_rx_valid && (i_rx_data == '0);
  assign load_last  = (state == S_LOAD_DATA) && i_rx_valid && byte_last &&
                      (words_left == NB_BYTE'(1));

  // Gating with i_halt keeps a halted core from getting any further enable cycle.
  assign o_mips_enable = ((state == S_RUN) && !i_halt) || (state == S_STEP);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_nxt = S_LOAD_CNT;
            CMD_RUN:  state_nxt = S_RUN;
            CMD_STEP: state_nxt = S_STEP;
            default:  state_nxt = S_IDLE;
          endcase
        end
      S_LOAD_CNT:
        if (i_rx_valid) state_nxt = (i_rx_data == '0) ? S_IDLE : S_LOAD_DATA;
      S_LOAD_DATA:
        if (load_last) state_nxt = S_IDLE;
      S_RUN:
        if (i_halt) state_nxt = S_DUMP_FETCH;
      S_STEP:
        state_nxt = S_DUMP_FETCH;
      S_DUMP_FETCH:
        state_nxt = S_DUMP_SEND;
      S_DUMP_SEND:
        if (o_tx_start) state_nxt = S_DUMP_WAIT;
      S_DUMP_WAIT:
        if (frame_done)     state_nxt = S_IDLE;
        else if (word_done) state_nxt = S_DUMP_FETCH;
        else                state_nxt = S_DUMP_SEND;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      asm_word       <= '0;
      byte_idx       <= '0;
      words_left     <= '0;
      word_addr      <= '0;
      o_imem_wr_enb  <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
    end else begin
      o_imem_wr_enb <= 1'b0;
      if (state == S_LOAD_CNT && i_rx_valid) begin
        words_left <= i_rx_data;
        word_addr  <= '0;
        byte_idx   <= '0;
      end else if (state == S_LOAD_DATA && i_rx_valid) begin
        asm_word <= ASM_W'({asm_word, i_rx_data});
        if (byte_last) begin
          byte_idx       <= '0;
          o_imem_wr_enb  <= 1'b1;
          o_imem_wr_addr <= word_addr;
          o_imem_wr_data <= {asm_word, i_rx_data};
          word_addr      <= word_addr + 1'b1;
          words_left     <= words_left - 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // A finished (or empty) load starts a fresh measurement window.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cycle_cnt <= '0;
      word_idx  <= '0;
    end else begin
      if (load_empty || load_last)                     cycle_cnt <= '0;
      else if (o_mips_enable && cycle_cnt != CNT_MAX)  cycle_cnt <= cycle_cnt + 1'b1;

      if (state == S_IDLE)            word_idx <= '0;
      else if (state == S_DUMP_FETCH) word_idx <= word_idx + 1'b1;
    end
  end

  always_comb begin
    fetch_word  = i_dump_data;
    o_dump_addr = '0;
    if (word_idx == '0) begin
      fetch_word = i_pc;
    end else if (word_idx == 6'(FRAME_WORDS - 1)) begin
      fetch_word = NB_DATA'(cycle_cnt);
    end else if (state == S_DUMP_FETCH) begin
      o_dump_addr = NB_REG_ADDR'(word_idx - 6'd1);
    end
  end

  debug_tx_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk        (i_clock),
    .rst_n      (i_reset),
    .load       (state == S_DUMP_FETCH),
    .word       (fetch_word),
    .send       (state == S_DUMP_SEND),
    .waiting    (state == S_DUMP_WAIT),
    .tx_ready   (i_tx_ready),
    .tx_data    (o_tx_data),
    .tx_start   (o_tx_start),
    .word_done  (word_done),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected tx bytes and imem writes are queued
// as stimulus is driven and checked when the DUT strobes them out.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready = 1'b1;
  logic        wr_enb;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mips_enable;
  logic        halt = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic [31:0] reg_base = '0;

  always #5 clk = ~clk;

  // Register file model: combinational read.
  assign dump_data = reg_base + 32'(dump_addr);

  debug_unit dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .i_tx_ready     (tx_ready),
    .o_imem_wr_enb  (wr_enb),
    .o_imem_wr_addr (wr_addr),
    .o_imem_wr_data (wr_data),
    .o_mips_enable  (mips_enable),
    .i_halt         (halt),
    .i_pc           (pc),
    .o_dump_addr    (dump_addr),
    .i_dump_data    (dump_data)
  );

  int checks = 0, failures = 0;
  int tx_seen = 0, wr_seen = 0, en_cycles = 0;
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mips_enable) en_cycles++;
      if (tx_start) begin
        check("tx_while_busy", tx_ready, 1);
        if (wr_enb) check("tx_wr_overlap", 1, 0);
        if (exp_tx.size() == 0) check("tx_extra", 1, 0);
        else check($sformatf("tx_byte%0d", tx_seen), tx_data, exp_tx.pop_front());
        tx_seen++;
      end
      if (wr_enb) begin
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else check($sformatf("wr%0d", wr_seen), {wr_addr, wr_data}, exp_wr.pop_front());
        wr_seen++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] base, input logic [31:0] cnt);
    push_word(p);
    for (int r = 0; r < 32; r++) push_word(base + 32'(r));
    push_word(cnt);
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 3000 && exp_tx.size() != 0; i++) @(negedge clk);
    check(tag, exp_tx.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int base);
    for (int i = 0; i < 3000 && (tx_seen - base) < n; i++) @(posedge clk);
    check("reach_tx_count", (tx_seen - base) >= n, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"},      mips_enable, 0);
    check({tag, "_txs"},     tx_start, 0);
    check({tag, "_txd"},     tx_data, 0);
    check({tag, "_wren"},    wr_enb, 0);
    check({tag, "_wraddr"},  wr_addr, 0);
    check({tag, "_wrdata"},  wr_data, 0);
    check({tag, "_dumpadr"}, dump_addr, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] load_seq [10];
    int w0, t0, ts;
    load_seq = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h3F};

    #3 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray byte in IDLE, then a two-word load.
    send_byte(8'h11);
    exp_wr.push_back({8'h00, 32'h2001_0005});
    exp_wr.push_back({8'h01, 32'h0000_003F});
    foreach (load_seq[i]) send_byte(load_seq[i]);
    repeat (4) @(negedge clk);
    check("load_wr_count", wr_seen, 2);
    check("load_wr_pending", exp_wr.size(), 0);
    check("load_no_enable", en_cycles, 0);

    // Empty load.
    w0 = wr_seen;
    send_byte(8'h4C);
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    check("load0_no_wr", wr_seen, w0);

    // Continuous run, halt after 10 enable cycles; counter cleared by the load.
    pc = 32'h0000_0100;
    reg_base = 32'h1234_0000;
    en_cycles = 0;
    t0 = tx_seen;
    push_frame(32'h0000_0100, 32'h1234_0000, 32'd10);
    send_byte(8'h43);
    repeat (10) @(posedge clk);
    #1 halt = 1'b1;
    wait_frame("run_frame_drained");
    check("run_en_cycles", en_cycles, 10);
    check("run_frame_len", tx_seen - t0, 136);
    halt = 1'b0;

    // Single step with a 50-cycle tx stall; rx bytes during the dump are discarded.
    reset_pulse();
    pc = 32'h4;
    reg_base = '0;
    en_cycles = 0;
    w0 = wr_seen;
    t0 = tx_seen;
    push_frame(32'h4, 32'h0, 32'd1);
    send_byte(8'h53);
    wait_tx(40, t0);
    #1 tx_ready = 1'b0;
    ts = tx_seen;
    fork
      repeat (50) @(posedge clk);
      begin
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      end
    join
    check("stall_no_tx", tx_seen, ts);
    #1 tx_ready = 1'b1;
    wait_frame("step_frame_drained");
    check("step_en_cycles", en_cycles, 1);
    check("step_frame_len", tx_seen - t0, 136);
    check("dump_rx_discarded", wr_seen, w0);

    // Reset in the middle of a dump, then a clean step frame.
    t0 = tx_seen;
    push_frame(32'h4, 32'h0, 32'd2);
    send_byte(8'h53);
    wait_tx(70, t0);
    #1 rst_n = 1'b0;
    #1 check_zero("midreset");
    check("midreset_at70", tx_seen - t0, 70);
    exp_tx.delete();
    @(negedge clk);
    rst_n = 1'b1;
    en_cycles = 0;
    t0 = tx_seen;
    push_frame(32'h4, 32'h0, 32'd1);
    send_byte(8'h53);
    wait_frame("post_reset_frame_drained");
    check("post_reset_frame_len", tx_seen - t0, 136);
    check("post_reset_en_cycles", en_cycles, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
